// File: rtl/buf_pkg.sv
// Shared types and sizing helpers for the elastic buffer chain.
package buf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // Bits needed to count 0..2*depth stored words.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/buf_elastic_chain_if.sv
// Valid/ready word channel used on both sides of the elastic chain.
interface buf_elastic_chain_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/buf_skid_stage.sv
// One two-entry skid stage: main register drives downstream, skid register
// catches the word that arrives while downstream stalls.
module buf_skid_stage
  import buf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  output logic             up_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic             dn_valid,
  input  logic             dn_ready
);

  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             up_ready_q, dn_valid_q;
  logic             up_acc, dn_acc;
  logic             load_main, load_skid, skid_to_main;

  assign up_acc = up_valid & up_ready_q;
  assign dn_acc = dn_valid_q & dn_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_q)
      EMPTY: begin
        if (up_acc) begin
          state_d   = HALF;
          load_main = 1'b1;
        end
      end
      HALF: begin
        if (up_acc && dn_acc) begin
          load_main = 1'b1;
        end else if (up_acc) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (dn_acc) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // up_ready is low here, so only the downstream side can move.
        if (dn_acc) begin
          state_d      = HALF;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d      = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  // Control: handshake flags are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      up_ready_q <= (state_d != FULL);
      dn_valid_q <= (state_d != EMPTY);
    end
  end

  // Data: cleared on reset so the output is never X; held while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= up_data;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= up_data;
      end
    end
  end

  assign up_ready = up_ready_q;
  assign dn_valid = dn_valid_q;
  assign dn_data  = main_q;

endmodule

// File: rtl/buf_elastic_chain.sv
// Elastic chain of DEPTH skid stages with a per-bit inversion mask applied
// once at the input and a saturating word-occupancy counter.
module buf_elastic_chain
  import buf_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] INV_MASK = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  buf_elastic_chain_if.slave           in_bus,
  buf_elastic_chain_if.master          out_bus,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int               OCC_W   = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] MAX_OCC = OCC_W'(2 * DEPTH);

  logic [DEPTH:0][WIDTH-1:0] data_p;
  logic [DEPTH:0]            vld_p;
  logic [DEPTH:0]            rdy_p;
  logic                      in_acc, out_acc;

  assign data_p[0]     = in_bus.data ^ INV_MASK;
  assign vld_p[0]      = in_bus.valid;
  assign in_bus.ready  = rdy_p[0];
  assign out_bus.data  = data_p[DEPTH];
  assign out_bus.valid = vld_p[DEPTH];
  assign rdy_p[DEPTH]  = out_bus.ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    buf_skid_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_data  (data_p[g]),
      .up_valid (vld_p[g]),
      .up_ready (rdy_p[g]),
      .dn_data  (data_p[g+1]),
      .dn_valid (vld_p[g+1]),
      .dn_ready (rdy_p[g+1])
    );
  end

  // A flushed cycle moves no words, so neither side counts as accepted.
  assign in_acc  = in_bus.valid & rdy_p[0] & ~flush;
  assign out_acc = vld_p[DEPTH] & out_bus.ready & ~flush;

  function automatic logic [OCC_W-1:0] occ_sat(input logic [OCC_W-1:0] cur,
                                               input logic             inc,
                                               input logic             dec);
    logic [OCC_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && cur != MAX_OCC) begin
      nxt = cur + 1'b1;
    end else if (dec && !inc && cur != '0) begin
      nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_sat(occupancy, in_acc, out_acc);
    end
  end

endmodule

// File: tb/tb_buf_elastic_chain.sv
// Bench for buf_elastic_chain: directed scenarios plus a scoreboard of input words.
module tb_buf_elastic_chain;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 2;
  localparam logic [7:0] MASK  = 8'h0F;
  localparam int         OCC_W = $clog2(2 * DEPTH + 1);

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [OCC_W-1:0] occupancy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  buf_elastic_chain_if #(.WIDTH(WIDTH)) in_if ();
  buf_elastic_chain_if #(.WIDTH(WIDTH)) out_if ();

  buf_elastic_chain #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .INV_MASK (MASK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_bus    (in_if),
    .out_bus   (out_if),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_if.ready); end
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_if.valid); end
    checks++; if (out_if.data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_if.data); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    rst_n = 1'b1;
    repeat (2) cyc();
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_if.ready); end
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b expected 0", out_if.valid); end
    checks++; if (out_if.data !== 8'h00) begin errors++; $display("FAIL release_out_data: got %h expected 00", out_if.data); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL release_occupancy: got %0d expected 0", occupancy); end
  endtask

  task automatic test_stream();
    out_if.ready = 1'b1;
    in_if.valid  = 1'b1;
    in_if.data   = 8'hA5;
    cyc();
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL stream_latency: out_valid %b one cycle after accept, expected 0", out_if.valid); end
    in_if.data = 8'h3C;
    cyc();
    checks++; if (out_if.valid !== 1'b1 || out_if.data !== 8'hAA) begin errors++; $display("FAIL stream_w0: got valid %b data %h expected 1/AA", out_if.valid, out_if.data); end
    in_if.data = 8'hFF;
    cyc();
    checks++; if (out_if.valid !== 1'b1 || out_if.data !== 8'h33) begin errors++; $display("FAIL stream_w1: got valid %b data %h expected 1/33", out_if.valid, out_if.data); end
    in_if.valid = 1'b0;
    cyc();
    checks++; if (out_if.valid !== 1'b1 || out_if.data !== 8'hF0) begin errors++; $display("FAIL stream_w2: got valid %b data %h expected 1/F0", out_if.valid, out_if.data); end
    cyc();
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %b expected 0", out_if.valid); end
    checks++; if (out_if.data !== 8'hF0) begin errors++; $display("FAIL stream_hold_data: got %h expected F0", out_if.data); end
  endtask

  task automatic test_fill();
    int         n;
    logic [7:0] d;
    n             = 0;
    d             = 8'h10;
    out_if.ready  = 1'b0;
    in_if.valid   = 1'b1;
    in_if.data    = d;
    for (int i = 0; i < 8; i++) begin
      logic r;
      r = in_if.ready;
      cyc();
      if (r) begin
        n++;
        d++;
        in_if.data = d;
      end
    end
    in_if.valid = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL fill_accepts: got %0d expected 4", n); end
    checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_if.ready); end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occupancy: got %0d expected 4", occupancy); end
    out_if.ready = 1'b1;
    cyc();
    cyc();
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL fill_ready_return: got %b expected 1", in_if.ready); end
    repeat (6) cyc();
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fill_drained_occ: got %0d expected 0", occupancy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fill_drained_words: %0d words missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_simul();
    logic [7:0] d;
    d            = 8'h40;
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.data   = d;
    repeat (2) begin
      cyc();
      d++;
      in_if.data = d;
    end
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL simul_start_occ: got %0d expected 2", occupancy); end
    out_if.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic r;
      r = in_if.ready;
      cyc();
      if (r) begin
        d++;
        in_if.data = d;
      end
      checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL simul_occ cycle %0d: got %0d expected 2", i, occupancy); end
    end
    in_if.valid = 1'b0;
    repeat (5) cyc();
    checks++; if (occupancy !== 3'd0 || exp_q.size() != 0) begin errors++; $display("FAIL simul_drain: occ %0d pending %0d expected 0/0", occupancy, exp_q.size()); end
  endtask

  task automatic test_flush();
    logic [7:0] d;
    d            = 8'h60;
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.data   = d;
    repeat (3) begin
      cyc();
      d++;
      in_if.data = d;
    end
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 3", occupancy); end
    flush      = 1'b1;
    in_if.data = 8'h77;
    cyc();
    flush       = 1'b0;
    in_if.valid = 1'b0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_if.valid); end
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_if.ready); end
    exp_q.delete();
    out_if.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL flush_dropped cycle %0d: out_valid %b data %h expected no word", i, out_if.valid, out_if.data); end
    end
    in_if.valid = 1'b1;
    in_if.data  = 8'h81;
    cyc();
    in_if.valid = 1'b0;
    repeat (4) cyc();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flush_recover: %0d words pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d            = 8'h90;
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.data   = d;
    repeat (3) begin
      cyc();
      d++;
      in_if.data = d;
    end
    in_if.valid = 1'b0;
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL rstmid_pre_occ: got %0d expected 3", occupancy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_if.valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rstmid_occ: got %0d expected 0", occupancy); end
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_if.ready); end
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    logic acc;
    acc         = 1'b0;
    in_if.valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!in_if.valid || acc) begin
        in_if.valid = ($urandom_range(0, 3) != 0);
        in_if.data  = 8'($urandom_range(0, 255));
      end
      out_if.ready = ($urandom_range(0, 1) != 0);
      acc = in_if.valid && in_if.ready;
      cyc();
      checks++; if (int'(occupancy) != exp_q.size()) begin errors++; $display("FAIL random_occ cycle %0d: got %0d expected %0d", i, occupancy, exp_q.size()); end
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    repeat (10) cyc();
    checks++; if (exp_q.size() != 0 || occupancy !== 3'd0) begin errors++; $display("FAIL random_drain: pending %0d occ %0d expected 0/0", exp_q.size(), occupancy); end
  endtask

  initial begin
    in_if.data   = '0;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    fork
      begin : monitor
        logic [7:0] e;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (out_if.valid && out_if.ready && !flush) begin
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got word %h, expected none", out_if.data);
              end else begin
                e = exp_q.pop_front();
                if (out_if.data !== e) begin
                  errors++;
                  $display("FAIL scoreboard_data: got %h expected %h", out_if.data, e);
                end
              end
            end
            if (in_if.valid && in_if.ready && !flush) exp_q.push_back(in_if.data ^ MASK);
          end
        end
      end
    join_none
    test_reset();
    test_stream();
    test_fill();
    test_simul();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
